// File: rtl/k_fifo_mem_writer.sv
// Result-FIFO to K_DSP memory writer: pops a latched number of words and writes
// them to consecutive addresses of one bank, reporting busy and a done pulse.
module k_fifo_mem_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int BANK_W = 2,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [BANK_W-1:0] bank,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [BANK_W-1:0] mem_bank,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  len_q;
  logic [BANK_W-1:0] bank_q;

  // Transfer parameters are captured only on an accepted start so that later
  // changes on the inputs cannot disturb a transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      bank_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            len_q   <= length;
            bank_q  <= bank;
            count_q <= '0;
          end
        end
        WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // An abort in FETCH suppresses the pop so no FIFO word is lost; in WRITE the
  // already-popped word is still written before returning to IDLE.
  always_comb begin
    state_nxt         = state;
    fifo_rd_en        = 1'b0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_bank          = '0;
    busy              = 1'b0;
    done              = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = WRITE;
        end
      end
      WRITE: begin
        busy              = 1'b1;
        mem_write_enable  = 1'b1;
        mem_write_address = addr_q;
        mem_write_data    = fifo_rd_data;
        mem_bank          = bank_q;
        if (abort) begin
          state_nxt = IDLE;
        end else if (count_q == len_q - 1'b1) begin
          state_nxt = DONE;
        end else begin
          state_nxt = FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_k_fifo_mem_writer.sv
// Scoreboard bench for k_fifo_mem_writer: expected writes are queued by the
// stimulus and matched by a monitor whenever the DUT strobes mem_write_enable.
module tb_k_fifo_mem_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [1:0]  bank;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        mem_write_enable;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic [1:0]  mem_bank;
  logic        busy;
  logic        done;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  bank;
    int          rel;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic        done_prev = 1'b0;

  k_fifo_mem_writer dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .base_addr         (base_addr),
    .length            (length),
    .bank              (bank),
    .fifo_empty        (fifo_empty),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_en        (fifo_rd_en),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_bank          (mem_bank),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (fifo_rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (done_prev) begin
        errors++;
        $display("[TB] FAIL done_single: done high for consecutive cycles at cycle %0d, required one cycle", cyc);
      end
    end
    done_prev = done;
    checks++;
    if (mem_write_enable) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%h data=%h bank=%0d, required no write",
                 mem_write_address, mem_write_data, mem_bank);
      end else begin
        e = sb.pop_front();
        if (mem_write_address !== e.addr || mem_write_data !== e.data || mem_bank !== e.bank ||
            (e.rel >= 0 && (cyc - start_cyc) != e.rel)) begin
          errors++;
          $display("[TB] FAIL write: got addr=%h data=%h bank=%0d rel=%0d, required addr=%h data=%h bank=%0d rel=%0d",
                   mem_write_address, mem_write_data, mem_bank, cyc - start_cyc,
                   e.addr, e.data, e.bank, e.rel);
        end
      end
    end else if (mem_write_address !== '0 || mem_write_data !== '0 || mem_bank !== '0) begin
      errors++;
      $display("[TB] FAIL idle_bus: got addr=%h data=%h bank=%0d, required all 0",
               mem_write_address, mem_write_data, mem_bank);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic fifoPush(input logic [15:0] d0, input int n);
    for (int i = 0; i < n; i++) fq.push_back(d0 + 16'(i));
  endtask

  task automatic expectWrites(input logic [7:0] b, input int n, input logic [1:0] bk,
                              input logic [15:0] d0, input int rel0);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = b + 8'(i);
      e.data = d0 + 16'(i);
      e.bank = bk;
      e.rel  = (rel0 >= 0) ? rel0 + 2 * i : -1;
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [8:0] n, input logic [1:0] bk);
    base_addr = b;
    length    = n;
    bank      = bk;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
    base_addr = 8'h77;
    length    = 9'd1;
    bank      = 2'd0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) break;
    end
    checkOutput(name, done_cnt - d0, 1);
  endtask

  initial begin
    int w0, r0, d0;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; bank = '0;
    tick(); tick();
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rd_en", int'(fifo_rd_en), 0);
    checkOutput("reset_we", int'(mem_write_enable), 0);
    reset = 1'b1;
    tick(); tick();

    // Test 1: basic transfer, mid-transfer input changes and re-start ignored
    fifoPush(16'hA001, 4);
    expectWrites(8'h10, 4, 2'd2, 16'hA001, 2);
    tick();
    r0 = rd_cnt;
    applyStimulus(8'h10, 9'd4, 2'd2);
    checkOutput("t1_busy", int'(busy), 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone("t1_done_seen", 20);
    checkOutput("t1_done_cycle", done_cyc - start_cyc, 9);
    checkOutput("t1_pops", rd_cnt - r0, 4);
    tick(); tick();
    checkOutput("t1_busy_after", int'(busy), 0);

    // Test 2: zero length goes straight to DONE
    w0 = wr_cnt; r0 = rd_cnt;
    applyStimulus(8'h30, 9'd0, 2'd1);
    waitDone("t2_done_seen", 10);
    checkOutput("t2_done_cycle", done_cyc - start_cyc, 1);
    checkOutput("t2_pops", rd_cnt - r0, 0);
    checkOutput("t2_writes", wr_cnt - w0, 0);
    tick();

    // Test 3: address wraps 0xFF -> 0x00 within the same bank
    fifoPush(16'hB001, 3);
    expectWrites(8'hFE, 3, 2'd3, 16'hB001, 2);
    tick();
    applyStimulus(8'hFE, 9'd3, 2'd3);
    waitDone("t3_done_seen", 20);
    checkOutput("t3_done_cycle", done_cyc - start_cyc, 7);
    tick();

    // Test 4: FIFO runs dry mid-transfer for 5 cycles
    w0 = wr_cnt;
    fifoPush(16'hC001, 2);
    expectWrites(8'h40, 4, 2'd1, 16'hC001, -1);
    tick();
    applyStimulus(8'h40, 9'd4, 2'd1);
    for (int i = 0; i < 20 && (wr_cnt - w0) < 2; i++) tick();
    checkOutput("t4_first_two", wr_cnt - w0, 2);
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t4_stall_writes", wr_cnt - w0, 2);
    checkOutput("t4_stall_pops", rd_cnt - r0, 0);
    checkOutput("t4_stall_busy", int'(busy), 1);
    fifoPush(16'hC003, 2);
    waitDone("t4_done_seen", 20);
    checkOutput("t4_total", wr_cnt - w0, 4);
    tick();

    // Test 5: abort during the WRITE of word 2 of 4
    w0 = wr_cnt; d0 = done_cnt;
    fifoPush(16'hD001, 4);
    expectWrites(8'h80, 2, 2'd2, 16'hD001, 2);
    tick();
    applyStimulus(8'h80, 9'd4, 2'd2);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t5_writes", wr_cnt - w0, 2);
    checkOutput("t5_no_done", done_cnt - d0, 0);
    checkOutput("t5_fifo_left", fq.size(), 2);
    fq.delete();
    tick(); tick();

    // Test 7: abort together with start in IDLE, start wins
    fifoPush(16'hE001, 1);
    expectWrites(8'h05, 1, 2'd0, 16'hE001, 2);
    tick();
    abort = 1'b1;
    applyStimulus(8'h05, 9'd1, 2'd0);
    abort = 1'b0;
    waitDone("t7_done_seen", 10);
    checkOutput("t7_done_cycle", done_cyc - start_cyc, 3);
    tick();

    // Test 6: reset while stalled in FETCH, with an ignored re-start
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    applyStimulus(8'h20, 9'd3, 2'd1);
    tick(); tick();
    checkOutput("t6_busy_stall", int'(busy), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_we", int'(mem_write_enable), 0);
    checkOutput("t6_rst_rd_en", int'(fifo_rd_en), 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    fifoPush(16'hF001, 3);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t6_writes", wr_cnt - w0, 0);
    checkOutput("t6_pops", rd_cnt - r0, 0);
    checkOutput("t6_no_done", done_cnt - d0, 0);
    checkOutput("t6_busy", int'(busy), 0);
    fq.delete();

    checkOutput("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
